// File: rtl/rx_pkg.sv
// -----------------------------------------------------------------------------
// rx_pkg
// Shared definitions for the receive-side I/Q packer: capture mode encodings,
// packer FSM state encoding, default burst length and the ADC sample
// sign-extension helper.
// -----------------------------------------------------------------------------
package rx_pkg;

    typedef enum logic [1:0] {
        MODE_IQ    = 2'd0,
        MODE_IPACK = 2'd1,
        MODE_TEST  = 2'd2,
        MODE_RSVD  = 2'd3
    } mode_e;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ARM   = 2'd1,
        RUN   = 2'd2,
        FLUSH = 2'd3
    } state_e;

    localparam int unsigned BURST_WORDS_DEFAULT = 16;

    // Extend a w-bit two's complement value (right-justified in v) to 16 bits
    // by replicating bit w-1 into the upper positions.
    function automatic logic [15:0] sext(input logic [15:0] v, input int unsigned w);
        logic [15:0] r;
        r = '0;
        for (int unsigned b = 0; b < 16; b++) begin
            r[b] = (b < w) ? v[b] : v[w-1];
        end
        return r;
    endfunction

endpackage

// File: rtl/rx_iq_packer.sv
// -----------------------------------------------------------------------------
// rx_iq_packer
// Packs parallel ADC I/Q samples into 32-bit stream words for the
// stream-to-AXI bridge. Every capture session is padded with zero words so
// the session length is a whole number of BURST_WORDS-word bursts.
//
// Ports:
//   Sclk      stream clock, rising edge
//   rst       synchronous active-high reset (aborts a session, no flush)
//   en        capture enable level
//   mode      0=IQ, 1=I-only packed pairs, 2=test counter, 3=as 0
//   adc_i     I sample, IW-bit two's complement
//   adc_q     Q sample, IW-bit two's complement
//   adc_valid sample strobe
//   Sin       packed word to the bridge
//   Ien       one-cycle write strobe qualifying Sin
//   sync      one-cycle pulse at session start (ARM)
//   busy      high whenever the packer is not IDLE
//   scnt      samples accepted this session
//   wcnt      words emitted this session, pads included
// -----------------------------------------------------------------------------
module rx_iq_packer
    import rx_pkg::*;
#(
    parameter int unsigned IW          = 12,
    parameter int unsigned BURST_WORDS = BURST_WORDS_DEFAULT
) (
    input  logic          Sclk,
    input  logic          rst,
    input  logic          en,
    input  logic [1:0]    mode,
    input  logic [IW-1:0] adc_i,
    input  logic [IW-1:0] adc_q,
    input  logic          adc_valid,
    output logic [31:0]   Sin,
    output logic          Ien,
    output logic          sync,
    output logic          busy,
    output logic [31:0]   scnt,
    output logic [31:0]   wcnt
);

    localparam logic [31:0] BURST_MASK = 32'(BURST_WORDS - 1);

    state_e      state_q, state_n;
    mode_e       mode_q, mode_n;
    logic [15:0] hold_q, hold_n;
    logic        pend_q, pend_n;
    logic [31:0] sin_n, scnt_n, wcnt_n;
    logic        ien_n, sync_n, busy_n;
    logic [15:0] i16, q16;

    assign i16 = sext(16'(adc_i), IW);
    assign q16 = sext(16'(adc_q), IW);

    // All outputs are computed one cycle ahead from the next state so that
    // they leave the module straight from flops.
    always_comb begin
        state_n = state_q;
        mode_n  = mode_q;
        hold_n  = hold_q;
        pend_n  = pend_q;
        sin_n   = '0;
        ien_n   = 1'b0;
        sync_n  = 1'b0;
        scnt_n  = scnt;
        wcnt_n  = wcnt;

        unique case (state_q)
            IDLE: begin
                if (en) begin
                    state_n = ARM;
                    sync_n  = 1'b1;
                    scnt_n  = '0;
                    wcnt_n  = '0;
                    pend_n  = 1'b0;
                    hold_n  = '0;
                    mode_n  = (mode_e'(mode) == MODE_RSVD) ? MODE_IQ : mode_e'(mode);
                end
            end

            ARM: begin
                state_n = RUN;
            end

            RUN: begin
                if (!en) begin
                    state_n = FLUSH;
                end
                if (adc_valid) begin
                    scnt_n = scnt + 32'd1;
                    unique case (mode_q)
                        MODE_IPACK: begin
                            if (pend_q) begin
                                sin_n  = {i16, hold_q};
                                ien_n  = 1'b1;
                                pend_n = 1'b0;
                            end else begin
                                hold_n = i16;
                                pend_n = 1'b1;
                            end
                        end
                        MODE_TEST: begin
                            sin_n = wcnt;
                            ien_n = 1'b1;
                        end
                        default: begin
                            sin_n = {q16, i16};
                            ien_n = 1'b1;
                        end
                    endcase
                end
            end

            FLUSH: begin
                // Pending half word first, then zero pads until aligned; the
                // aligned cycle itself emits nothing and returns to IDLE.
                if (pend_q) begin
                    sin_n  = {16'h0000, hold_q};
                    ien_n  = 1'b1;
                    pend_n = 1'b0;
                end else if ((wcnt & BURST_MASK) != 32'd0) begin
                    ien_n = 1'b1;
                end else begin
                    state_n = IDLE;
                end
            end

            default: state_n = IDLE;
        endcase

        if (ien_n) begin
            wcnt_n = wcnt + 32'd1;
        end

        busy_n = (state_n != IDLE);
    end

    always_ff @(posedge Sclk) begin
        if (rst) begin
            state_q <= IDLE;
            mode_q  <= MODE_IQ;
            hold_q  <= '0;
            pend_q  <= 1'b0;
            Sin     <= '0;
            Ien     <= 1'b0;
            sync    <= 1'b0;
            busy    <= 1'b0;
            scnt    <= '0;
            wcnt    <= '0;
        end else begin
            state_q <= state_n;
            mode_q  <= mode_n;
            hold_q  <= hold_n;
            pend_q  <= pend_n;
            Sin     <= sin_n;
            Ien     <= ien_n;
            sync    <= sync_n;
            busy    <= busy_n;
            scnt    <= scnt_n;
            wcnt    <= wcnt_n;
        end
    end

endmodule
